// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default sizing.
package clk_period_meter_pkg;

  // Measurement FSM: IDLE waits for an arming edge, MEAS times full periods.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } meas_state_e;

  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Synchronizer plus rising-edge detector for a slow asynchronous input.
// Reusable for buttons and tick inputs; exposes the combinational rise for
// same-cycle consumers and a registered one-cycle pulse.
module clk_period_meter_sync_edge_det
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic sync_o,
  output logic rise_c_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   rise_q;

  // Next value of the synchronizer shift chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
  end

  // Synchronizer chain, history flop and registered rise pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_o;
      rise_q <= rise_c_o;
    end
  end

  assign sync_o   = sync_q[SYNC_STAGES-1];
  assign rise_c_o = sync_o & ~hist_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// CLK_In cycles and offers each result over a one-deep valid/ready slot.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 CLK_In,
  input  logic                 RST,
  input  logic                 SIG_In,
  output logic                 SIG_Rise,
  output logic                 MEAS_Valid,
  input  logic                 MEAS_Ready,
  output logic [CNT_WIDTH-1:0] MEAS_Period,
  output logic [CNT_WIDTH-1:0] MEAS_High,
  output logic                 MEAS_Ovf,
  output logic                 MEAS_Drop
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 sync;
  logic                 rise_c;

  logic [CNT_WIDTH-1:0] per_q, per_d;
  logic [CNT_WIDTH-1:0] hi_q, hi_d;
  meas_state_e          state_q, state_d;
  logic                 publish_c;
  logic                 pub_ovf_c;

  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] res_per_q, res_per_d;
  logic [CNT_WIDTH-1:0] res_hi_q, res_hi_d;
  logic                 res_ovf_q, res_ovf_d;
  logic                 drop_q, drop_d;

  clk_period_meter_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i   (CLK_In),
    .rst_i   (RST),
    .sig_i   (SIG_In),
    .sync_o  (sync),
    .rise_c_o(rise_c),
    .rise_o  (SIG_Rise)
  );

  // Period and high-time counters: restart on a rise, otherwise saturate upward.
  always_comb begin
    per_d = per_q;
    hi_d  = hi_q;
    if (rise_c) begin
      per_d = CNT_WIDTH'(1);
      hi_d  = CNT_WIDTH'(1);
    end else begin
      if (per_q != CNT_MAX) per_d = per_q + CNT_WIDTH'(1);
      if (sync && (hi_q != CNT_MAX)) hi_d = hi_q + CNT_WIDTH'(1);
    end
  end

  // FSM next state; decides when a finished measurement is published.
  always_comb begin
    state_d   = state_q;
    publish_c = 1'b0;
    pub_ovf_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_c) state_d = ST_MEAS;
      end
      ST_MEAS: begin
        if (rise_c) begin
          publish_c = 1'b1;
        end else if (per_q == CNT_MAX) begin
          publish_c = 1'b1;
          pub_ovf_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result slot: load when free or being consumed, otherwise drop the new result.
  always_comb begin
    valid_d   = valid_q;
    res_per_d = res_per_q;
    res_hi_d  = res_hi_q;
    res_ovf_d = res_ovf_q;
    drop_d    = 1'b0;
    if (publish_c) begin
      if (!valid_q || MEAS_Ready) begin
        valid_d   = 1'b1;
        res_per_d = per_q;
        res_hi_d  = hi_q;
        res_ovf_d = pub_ovf_c;
      end else begin
        drop_d = 1'b1;
      end
    end else if (valid_q && MEAS_Ready) begin
      valid_d = 1'b0;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge CLK_In or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      per_q     <= '0;
      hi_q      <= '0;
      valid_q   <= 1'b0;
      res_per_q <= '0;
      res_hi_q  <= '0;
      res_ovf_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      valid_q   <= valid_d;
      res_per_q <= res_per_d;
      res_hi_q  <= res_hi_d;
      res_ovf_q <= res_ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign MEAS_Valid  = valid_q;
  assign MEAS_Period = res_per_q;
  assign MEAS_High   = res_hi_q;
  assign MEAS_Ovf    = res_ovf_q;
  assign MEAS_Drop   = drop_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: two instances (16-bit and 4-bit counters) share
// stimulus; a reference model derives results from input rise timestamps.
module tb_clk_period_meter;

  localparam int S  = 2;
  localparam int NE = 8192;

  logic clk;
  logic rst, sig, rdy;
  logic rise_a, valid_a, ovf_a, drop_a;
  logic [15:0] per_a, hi_a;
  logic rise_b, valid_b, ovf_b, drop_b;
  logic [3:0] per_b, hi_b;

  clk_period_meter #(.CNT_WIDTH(16), .SYNC_STAGES(S)) u_dut_a (
    .CLK_In(clk), .RST(rst), .SIG_In(sig), .SIG_Rise(rise_a),
    .MEAS_Valid(valid_a), .MEAS_Ready(rdy), .MEAS_Period(per_a),
    .MEAS_High(hi_a), .MEAS_Ovf(ovf_a), .MEAS_Drop(drop_a));

  clk_period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(S)) u_dut_b (
    .CLK_In(clk), .RST(rst), .SIG_In(sig), .SIG_Rise(rise_b),
    .MEAS_Valid(valid_b), .MEAS_Ready(rdy), .MEAS_Period(per_b),
    .MEAS_High(hi_b), .MEAS_Ovf(ovf_b), .MEAS_Drop(drop_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = 0;

  // Reference model state: input sample history, scheduled publishes, output slot.
  bit rise_at [NE];
  bit pv [2][NE];
  int pp [2][NE];
  int ph [2][NE];
  bit po [2][NE];
  int pre [NE+1];
  bit prev_s;
  bit armed [2];
  int last [2];
  int maxv [2] = '{65535, 15};
  bit mv [2];
  int mper [2];
  int mhi [2];
  bit movf [2];
  bit mdrop [2];
  bit mrise;

  bit t6_on = 1'b0;
  int t6_rises = 0, t6_cnt = 0, t6_sum = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    prev_s = 1'b0;
    mrise  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      armed[k] = 1'b0; mv[k] = 1'b0; mper[k] = 0; mhi[k] = 0;
      movf[k] = 1'b0; mdrop[k] = 1'b0;
    end
    for (int i = n; i < n + S + 1 && i < NE; i++) begin
      rise_at[i] = 1'b0;
      pv[0][i] = 1'b0;
      pv[1][i] = 1'b0;
    end
  endtask

  // One clock edge of the model: s/r are the input values during the cycle before edge n.
  task automatic model_edge(input bit s, input bit r);
    bit rise;
    if (n + S + 1 >= NE) begin
      errors++;
      $display("FAIL budget: cycle index %0d exceeds model capacity %0d", n, NE);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "cycle budget exhausted");
    end
    pre[n+1] = pre[n] + int'(s);
    rise = s && !prev_s;
    rise_at[n+S] = rise;
    for (int k = 0; k < 2; k++) begin
      pv[k][n+S] = 1'b0;
      if (rise) begin
        if (armed[k]) begin
          pv[k][n+S] = 1'b1; pp[k][n+S] = n - last[k];
          ph[k][n+S] = pre[n] - pre[last[k]]; po[k][n+S] = 1'b0;
        end
        armed[k] = 1'b1;
        last[k]  = n;
      end else if (armed[k] && (n - last[k] == maxv[k])) begin
        pv[k][n+S] = 1'b1; pp[k][n+S] = maxv[k];
        ph[k][n+S] = pre[n] - pre[last[k]]; po[k][n+S] = 1'b1;
        armed[k] = 1'b0;
      end
    end
    prev_s = s;
    mrise = rise_at[n];
    for (int k = 0; k < 2; k++) begin
      mdrop[k] = 1'b0;
      if (pv[k][n]) begin
        if (!mv[k] || r) begin
          mv[k] = 1'b1; mper[k] = pp[k][n]; mhi[k] = ph[k][n]; movf[k] = po[k][n];
        end else begin
          mdrop[k] = 1'b1;
        end
      end else if (mv[k] && r) begin
        mv[k] = 1'b0;
      end
    end
    n++;
  endtask

  task automatic compare_all();
    chk("rise_a",   32'(rise_a),  32'(mrise));
    chk("valid_a",  32'(valid_a), 32'(mv[0]));
    chk("period_a", 32'(per_a),   32'(mper[0]));
    chk("high_a",   32'(hi_a),    32'(mhi[0]));
    chk("ovf_a",    32'(ovf_a),   32'(movf[0]));
    chk("drop_a",   32'(drop_a),  32'(mdrop[0]));
    chk("rise_b",   32'(rise_b),  32'(mrise));
    chk("valid_b",  32'(valid_b), 32'(mv[1]));
    chk("period_b", 32'(per_b),   32'(mper[1]));
    chk("high_b",   32'(hi_b),    32'(mhi[1]));
    chk("ovf_b",    32'(ovf_b),   32'(movf[1]));
    chk("drop_b",   32'(drop_b),  32'(mdrop[1]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rise_a"},   32'(rise_a),  32'(0));
    chk({tag, "_valid_a"},  32'(valid_a), 32'(0));
    chk({tag, "_period_a"}, 32'(per_a),   32'(0));
    chk({tag, "_high_a"},   32'(hi_a),    32'(0));
    chk({tag, "_ovf_a"},    32'(ovf_a),   32'(0));
    chk({tag, "_drop_a"},   32'(drop_a),  32'(0));
    chk({tag, "_valid_b"},  32'(valid_b), 32'(0));
    chk({tag, "_period_b"}, 32'(per_b),   32'(0));
    chk({tag, "_high_b"},   32'(hi_b),    32'(0));
    chk({tag, "_ovf_b"},    32'(ovf_b),   32'(0));
    chk({tag, "_drop_b"},   32'(drop_b),  32'(0));
    chk({tag, "_rise_b"},   32'(rise_b),  32'(0));
  endtask

  // One clock cycle: called at posedge+1, optionally shifts input change to a random phase.
  task automatic cyc(input bit s, input bit r, input bit jit);
    if (jit) #($urandom_range(0, 7));
    sig = s;
    rdy = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    compare_all();
    if (t6_on) begin
      t6_rises += int'(rise_a);
      if (valid_a) begin
        t6_cnt++;
        t6_sum += int'(per_a);
        chk("t6_period_range", 32'(per_a inside {16'd7, 16'd8, 16'd9}), 32'(1));
      end
    end
  endtask

  // rmode: 0 = Ready low, 1 = Ready high, 2 = Ready random per cycle.
  task automatic wave(input int per, input int hi, input int reps, input int rmode, input bit jit);
    bit r;
    for (int rep = 0; rep < reps; rep++) begin
      for (int i = 0; i < per; i++) begin
        r = (rmode == 2) ? bit'($urandom_range(0, 1)) : bit'(rmode);
        cyc(i < hi, r, jit);
      end
    end
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int b, b_prev, per, hi;
    rst = 1'b1;
    sig = 1'b0;
    rdy = 1'b0;
    pre[0] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: divide-by-4 input, consumer always ready.
    wave(4, 2, 10, 1, 1'b0);
    chk("t1_period", 32'(per_a), 32'(4));
    chk("t1_high",   32'(hi_a),  32'(2));
    chk("t1_ovf",    32'(ovf_a), 32'(0));

    // 2: period 10 / high 3 with consumer stalled, then released.
    do_reset("t2_rst");
    wave(10, 3, 4, 0, 1'b0);
    chk("t2_held_valid",  32'(valid_a), 32'(1));
    chk("t2_held_period", 32'(per_a),   32'(10));
    chk("t2_held_high",   32'(hi_a),    32'(3));
    wave(10, 3, 2, 1, 1'b0);
    chk("t2_next_period", 32'(per_a), 32'(10));
    chk("t2_next_high",   32'(hi_a),  32'(3));

    // 3: raise Ready exactly on the cycle a new result is published.
    wave(10, 3, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bit r;
      r = pv[0][n];
      cyc((i % 10) < 3, r, 1'b0);
      if (r) begin
        chk("t3_valid_kept", 32'(valid_a), 32'(1));
        chk("t3_no_drop",    32'(drop_a),  32'(0));
        chk("t3_period",     32'(per_a),   32'(10));
      end
    end

    // 4: stopped input on the 4-bit instance overflows, then re-arms.
    wave(6, 2, 3, 1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("t4_ovf_valid",  32'(valid_b), 32'(1));
    chk("t4_ovf_flag",   32'(ovf_b),   32'(1));
    chk("t4_ovf_period", 32'(per_b),   32'(15));
    chk("t4_ovf_high",   32'(hi_b),    32'(2));
    wave(6, 2, 2, 1, 1'b0);
    chk("t4_rearm_period", 32'(per_b), 32'(6));
    chk("t4_rearm_high",   32'(hi_b),  32'(2));
    chk("t4_rearm_ovf",    32'(ovf_b), 32'(0));

    // 5: reset while a result is held and a period is in progress.
    wave(10, 3, 2, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t5_pre_valid", 32'(valid_a), 32'(1));
    do_reset("t5_rst");
    wave(10, 3, 1, 1, 1'b0);
    chk("t5_arm_only", 32'(valid_a), 32'(0));
    wave(10, 3, 2, 1, 1'b0);

    // 6: period-8 input with random edge placement and random sub-cycle phase.
    do_reset("t6_rst");
    t6_on = 1'b1;
    b_prev = 0;
    for (int k = 0; k < 60; k++) begin
      b = int'($urandom_range(0, 1));
      wave(8 + b - b_prev, 4, 1, 1, 1'b1);
      b_prev = b;
    end
    t6_on = 1'b0;
    chk("t6_rise_count",   32'(t6_rises), 32'(60));
    chk("t6_result_count", 32'(t6_cnt),   32'(59));
    chk("t6_mean", 32'((t6_sum >= 8 * t6_cnt - 1) && (t6_sum <= 8 * t6_cnt + 1)), 32'(1));

    // 7: random periods, duty cycles and Ready pattern against the model.
    do_reset("t7_rst");
    for (int k = 0; k < 40; k++) begin
      per = int'($urandom_range(4, 24));
      hi  = int'($urandom_range(1, per - 1));
      wave(per, hi, int'($urandom_range(1, 3)), 2, bit'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
